// File: rtl/pipe_ctrl.sv
// pipe_ctrl: hazard and stall controller for a five-stage pipeline.
// Drives per-stage load enables and flushes from load-use, redirect,
// instruction/data memory stalls and HALT.
// Optional performance counters are enabled with macro PIPE_CTRL_PERF_EN.
module pipe_ctrl (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] FD_rs,
    input  logic       FD_rs_vld,
    input  logic [2:0] FD_rt,
    input  logic       FD_rt_vld,
    input  logic       DX_memRead,
    input  logic       DX_regWrite,
    input  logic [2:0] DX_writeReg,
    input  logic       X_redirect,
    input  logic       imem_stall,
    input  logic       dmem_stall,
    input  logic       MW_halt,
    output logic       pc_en,
    output logic       FD_en,
    output logic       FD_flush,
    output logic       DX_en,
    output logic       DX_flush,
    output logic       XM_en,
    output logic       MW_en,
    output logic       halted
`ifdef PIPE_CTRL_PERF_EN
    ,
    output logic [15:0] stall_cycles,
    output logic [15:0] redirect_cnt
`endif
);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_IWAIT = 2'd1,
        ST_DWAIT = 2'd2,
        ST_HALT  = 2'd3
    } state_t;

    state_t state_q, state_d;
    logic   kill_q, kill_d;
    logic   load_use_s;
    logic   kill_flush_s;

    assign load_use_s = DX_memRead & DX_regWrite &
                        ((FD_rs_vld & (FD_rs == DX_writeReg)) |
                         (FD_rt_vld & (FD_rt == DX_writeReg)));

    // A pending kill discards the first valid fetch after an imem stall.
    assign kill_flush_s = kill_q & ~imem_stall;

    // State and pending-kill registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_RUN;
            kill_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            kill_q  <= kill_d;
        end
    end

    // Next state and next pending-kill.
    always_comb begin
        state_d = state_q;
        kill_d  = kill_q;
        case (state_q)
            ST_HALT: state_d = ST_HALT;
            ST_RUN, ST_IWAIT, ST_DWAIT: begin
                if (MW_halt & ~dmem_stall) begin
                    state_d = ST_HALT;
                end else if (dmem_stall) begin
                    state_d = ST_DWAIT;
                end else if (imem_stall) begin
                    state_d = ST_IWAIT;
                end else begin
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_RUN;
        endcase

        // The fetch in flight during a redirect under imem stall is stale;
        // remember that until the fetch completes. Frozen cycles hold it.
        if (state_q == ST_HALT) begin
            kill_d = kill_q;
        end else if (dmem_stall) begin
            kill_d = kill_q;
        end else if (X_redirect & imem_stall) begin
            kill_d = 1'b1;
        end else if (~imem_stall) begin
            kill_d = 1'b0;
        end else begin
            kill_d = kill_q;
        end
    end

    // Stage enables and flushes; combinational for zero-cycle response.
    always_comb begin
        pc_en    = 1'b1;
        FD_en    = 1'b1;
        FD_flush = 1'b0;
        DX_en    = 1'b1;
        DX_flush = 1'b0;
        XM_en    = 1'b1;
        MW_en    = 1'b1;
        halted   = 1'b0;
        if (state_q == ST_HALT) begin
            pc_en  = 1'b0;
            FD_en  = 1'b0;
            DX_en  = 1'b0;
            XM_en  = 1'b0;
            MW_en  = 1'b0;
            halted = 1'b1;
        end else if (dmem_stall) begin
            // Full freeze: redirect and load-use are ignored this cycle.
            pc_en = 1'b0;
            FD_en = 1'b0;
            DX_en = 1'b0;
            XM_en = 1'b0;
            MW_en = 1'b0;
        end else if (X_redirect) begin
            pc_en    = 1'b1;
            FD_flush = 1'b1;
            DX_flush = 1'b1;
        end else if (load_use_s) begin
            // Hold PC and FD, insert a bubble into DX.
            pc_en    = 1'b0;
            FD_en    = 1'b0;
            DX_flush = 1'b1;
            FD_flush = kill_flush_s;
        end else if (imem_stall) begin
            // Fetch not valid: hold PC, feed a NOP into FD, drain the rest.
            pc_en    = 1'b0;
            FD_en    = 1'b0;
            FD_flush = 1'b1;
        end else begin
            pc_en    = 1'b1;
            FD_flush = kill_flush_s;
        end
    end

`ifdef PIPE_CTRL_PERF_EN
    logic [15:0] stall_cycles_q;
    logic [15:0] redirect_cnt_q;
    logic        redirect_acc_s;

    assign redirect_acc_s = (state_q != ST_HALT) & ~dmem_stall & X_redirect;
    assign stall_cycles   = stall_cycles_q;
    assign redirect_cnt   = redirect_cnt_q;

    // Saturating stall/redirect counters, frozen while halted.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cycles_q <= 16'd0;
            redirect_cnt_q <= 16'd0;
        end else if (state_q != ST_HALT) begin
            if (~pc_en && (stall_cycles_q != 16'hFFFF)) begin
                stall_cycles_q <= stall_cycles_q + 16'd1;
            end else begin
                stall_cycles_q <= stall_cycles_q;
            end
            if (redirect_acc_s && (redirect_cnt_q != 16'hFFFF)) begin
                redirect_cnt_q <= redirect_cnt_q + 16'd1;
            end else begin
                redirect_cnt_q <= redirect_cnt_q;
            end
        end else begin
            stall_cycles_q <= stall_cycles_q;
            redirect_cnt_q <= redirect_cnt_q;
        end
    end
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: directed vectors push expected outputs,
// a negedge monitor pops and compares. Counter checks are compiled in when
// PIPE_CTRL_PERF_EN is defined.
module tb_pipe_ctrl;

    logic       clk;
    logic       rst;
    logic [2:0] FD_rs;
    logic       FD_rs_vld;
    logic [2:0] FD_rt;
    logic       FD_rt_vld;
    logic       DX_memRead;
    logic       DX_regWrite;
    logic [2:0] DX_writeReg;
    logic       X_redirect;
    logic       imem_stall;
    logic       dmem_stall;
    logic       MW_halt;
    logic       pc_en, FD_en, FD_flush, DX_en, DX_flush, XM_en, MW_en, halted;
`ifdef PIPE_CTRL_PERF_EN
    logic [15:0] stall_cycles;
    logic [15:0] redirect_cnt;
`endif

    pipe_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .FD_rs       (FD_rs),
        .FD_rs_vld   (FD_rs_vld),
        .FD_rt       (FD_rt),
        .FD_rt_vld   (FD_rt_vld),
        .DX_memRead  (DX_memRead),
        .DX_regWrite (DX_regWrite),
        .DX_writeReg (DX_writeReg),
        .X_redirect  (X_redirect),
        .imem_stall  (imem_stall),
        .dmem_stall  (dmem_stall),
        .MW_halt     (MW_halt),
        .pc_en       (pc_en),
        .FD_en       (FD_en),
        .FD_flush    (FD_flush),
        .DX_en       (DX_en),
        .DX_flush    (DX_flush),
        .XM_en       (XM_en),
        .MW_en       (MW_en),
        .halted      (halted)
`ifdef PIPE_CTRL_PERF_EN
        ,
        .stall_cycles(stall_cycles),
        .redirect_cnt(redirect_cnt)
`endif
    );

    // Output packing: {pc_en, FD_en, FD_flush, DX_en, DX_flush, XM_en, MW_en, halted}
    localparam logic [7:0] O_RUN = 8'b1101_0110; // all enables, no flush
    localparam logic [7:0] O_LU  = 8'b0001_1110; // load-use bubble
    localparam logic [7:0] O_RD  = 8'b1111_1110; // redirect
    localparam logic [7:0] O_IM  = 8'b0011_0110; // imem stall
    localparam logic [7:0] O_KF  = 8'b1111_0110; // run with forced FD kill
    localparam logic [7:0] O_FZ  = 8'b0000_0000; // dmem freeze
    localparam logic [7:0] O_HT  = 8'b0000_0001; // halted

    typedef struct packed {
        logic [7:0] exp;
        logic       rst_f;
        logic       redir;
    } exp_t;

    exp_t  sb_q[$];
    string nm_q[$];

    int n_checks = 0;
    int n_fail   = 0;
    int m_stall  = 0;
    int m_redir  = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle of inputs and record the expected response.
    task automatic apply(input string nm,
                         input logic [2:0] rs, input logic rsv,
                         input logic [2:0] rt, input logic rtv,
                         input logic mr, input logic rw, input logic [2:0] wr,
                         input logic xr, input logic im, input logic dm,
                         input logic hl, input logic [7:0] ex, input logic rs_f);
        exp_t e;
        @(posedge clk);
        #1;
        rst         = ~rs_f;
        FD_rs       = rs;
        FD_rs_vld   = rsv;
        FD_rt       = rt;
        FD_rt_vld   = rtv;
        DX_memRead  = mr;
        DX_regWrite = rw;
        DX_writeReg = wr;
        X_redirect  = xr;
        imem_stall  = im;
        dmem_stall  = dm;
        MW_halt     = hl;
        e.exp   = ex;
        e.rst_f = rs_f;
        e.redir = xr & ~dm & ~ex[0] & ~rs_f;
        sb_q.push_back(e);
        nm_q.push_back(nm);
    endtask

    task automatic ctl(input string nm, input logic xr, input logic im,
                       input logic dm, input logic hl, input logic [7:0] ex);
        apply(nm, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 3'd0, xr, im, dm, hl, ex, 1'b0);
    endtask

    // Monitor: compare presented outputs against the scoreboard head.
    always @(negedge clk) begin
        exp_t       e;
        string      nm;
        logic [7:0] act;
        if (sb_q.size() > 0) begin
            e   = sb_q.pop_front();
            nm  = nm_q.pop_front();
            act = {pc_en, FD_en, FD_flush, DX_en, DX_flush, XM_en, MW_en, halted};
            n_checks++;
            if (act !== e.exp) begin
                n_fail++;
                $display("FAIL %s: outputs got %b expected %b", nm, act, e.exp);
            end
`ifdef PIPE_CTRL_PERF_EN
            if (e.rst_f) begin
                m_stall = 0;
                m_redir = 0;
            end
            n_checks++;
            if (stall_cycles !== 16'(m_stall)) begin
                n_fail++;
                $display("FAIL %s: stall_cycles got %0d expected %0d", nm, stall_cycles, m_stall);
            end
            n_checks++;
            if (redirect_cnt !== 16'(m_redir)) begin
                n_fail++;
                $display("FAIL %s: redirect_cnt got %0d expected %0d", nm, redirect_cnt, m_redir);
            end
            if (!e.rst_f && !e.exp[0]) begin
                if (!e.exp[7]) m_stall++;
                if (e.redir) m_redir++;
            end
`endif
        end
    end

    initial begin
        rst = 1'b0;
        FD_rs = 3'd0; FD_rs_vld = 1'b0; FD_rt = 3'd0; FD_rt_vld = 1'b0;
        DX_memRead = 1'b0; DX_regWrite = 1'b0; DX_writeReg = 3'd0;
        X_redirect = 1'b0; imem_stall = 1'b0; dmem_stall = 1'b0; MW_halt = 1'b0;

        // Reset state
        apply("reset", 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, O_RUN, 1'b1);
        ctl("run_idle", 1'b0, 1'b0, 1'b0, 1'b0, O_RUN);

        // Load-use detection and its boundaries
        apply("lu_rs",     3'd3, 1'b1, 3'd0, 1'b0, 1'b1, 1'b1, 3'd3, 1'b0, 1'b0, 1'b0, 1'b0, O_LU, 1'b0);
        ctl("lu_after", 1'b0, 1'b0, 1'b0, 1'b0, O_RUN);
        apply("lu_rt",     3'd1, 1'b1, 3'd5, 1'b1, 1'b1, 1'b1, 3'd5, 1'b0, 1'b0, 1'b0, 1'b0, O_LU, 1'b0);
        apply("lu_novld",  3'd3, 1'b0, 3'd3, 1'b0, 1'b1, 1'b1, 3'd3, 1'b0, 1'b0, 1'b0, 1'b0, O_RUN, 1'b0);
        apply("lu_nowr",   3'd3, 1'b1, 3'd0, 1'b0, 1'b1, 1'b0, 3'd3, 1'b0, 1'b0, 1'b0, 1'b0, O_RUN, 1'b0);
        apply("lu_noload", 3'd3, 1'b1, 3'd0, 1'b0, 1'b0, 1'b1, 3'd3, 1'b0, 1'b0, 1'b0, 1'b0, O_RUN, 1'b0);
        apply("lu_nomatch",3'd2, 1'b1, 3'd4, 1'b1, 1'b1, 1'b1, 3'd3, 1'b0, 1'b0, 1'b0, 1'b0, O_RUN, 1'b0);

        // Redirect wins over load-use
        apply("rd_lu",     3'd3, 1'b1, 3'd0, 1'b0, 1'b1, 1'b1, 3'd3, 1'b1, 1'b0, 1'b0, 1'b0, O_RD, 1'b0);
        ctl("rd_after", 1'b0, 1'b0, 1'b0, 1'b0, O_RUN);

        // imem stall with redirect in its middle cycle, then the stale fetch is killed
        ctl("im_c0",    1'b0, 1'b1, 1'b0, 1'b0, O_IM);
        ctl("im_c1_rd", 1'b1, 1'b1, 1'b0, 1'b0, O_RD);
        ctl("im_c2",    1'b0, 1'b1, 1'b0, 1'b0, O_IM);
        ctl("im_kill",  1'b0, 1'b0, 1'b0, 1'b0, O_KF);
        ctl("im_clean", 1'b0, 1'b0, 1'b0, 1'b0, O_RUN);

        // dmem freeze swallows a redirect; re-presented redirect is accepted
        for (int i = 0; i < 4; i++) ctl("dm_frz_rd", 1'b1, 1'b0, 1'b1, 1'b0, O_FZ);
        ctl("dm_rd_again", 1'b1, 1'b0, 1'b0, 1'b0, O_RD);
        ctl("dm_after",    1'b0, 1'b0, 1'b0, 1'b0, O_RUN);

        // Pending kill survives a dmem freeze
        ctl("kp_set",   1'b1, 1'b1, 1'b0, 1'b0, O_RD);
        ctl("kp_frz",   1'b0, 1'b0, 1'b1, 1'b0, O_FZ);
        ctl("kp_kill",  1'b0, 1'b0, 1'b0, 1'b0, O_KF);
        ctl("kp_clean", 1'b0, 1'b0, 1'b0, 1'b0, O_RUN);

        // Second redirect while kill pending: single kill only
        ctl("dk_rd1",   1'b1, 1'b1, 1'b0, 1'b0, O_RD);
        ctl("dk_rd2",   1'b1, 1'b1, 1'b0, 1'b0, O_RD);
        ctl("dk_kill",  1'b0, 1'b0, 1'b0, 1'b0, O_KF);
        ctl("dk_clean", 1'b0, 1'b0, 1'b0, 1'b0, O_RUN);

        // Reset mid-IWAIT with kill pending resumes clean
        ctl("rk_rd",    1'b1, 1'b1, 1'b0, 1'b0, O_RD);
        ctl("rk_iwait", 1'b0, 1'b1, 1'b0, 1'b0, O_IM);
        apply("rk_rst", 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0, O_IM, 1'b1);
        ctl("rk_nokill", 1'b0, 1'b0, 1'b0, 1'b0, O_RUN);

        // HALT only after dmem stall drops, sticky until reset
        ctl("ht_dm",    1'b0, 1'b0, 1'b1, 1'b1, O_FZ);
        ctl("ht_go",    1'b0, 1'b0, 1'b0, 1'b1, O_RUN);
        ctl("ht_in",    1'b0, 1'b0, 1'b0, 1'b0, O_HT);
        ctl("ht_rd",    1'b1, 1'b0, 1'b0, 1'b0, O_HT);
        ctl("ht_im",    1'b0, 1'b1, 1'b0, 1'b0, O_HT);
        ctl("ht_dm2",   1'b0, 1'b0, 1'b1, 1'b0, O_HT);
        apply("ht_rst", 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, O_RUN, 1'b1);
        ctl("ht_run",   1'b0, 1'b0, 1'b0, 1'b0, O_RUN);
        ctl("ht_lu_ok", 1'b0, 1'b1, 1'b0, 1'b0, O_IM);

        repeat (3) @(posedge clk);
        n_checks++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: scoreboard left %0d expected 0", sb_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
